// File: rtl/mmu_tlb_lock_arbiter.sv
// N-channel TLB access lock with round-robin or fixed-priority arbitration,
// zero-gap owner handover, optional hold timeout and owner-selected lookup mux.
module mmu_tlb_lock_arbiter #(
    parameter int N_CHAN    = 2,
    parameter int ADDR_BITS = 48,
    parameter int PID_BITS  = 6,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 0,
    parameter int CH_BITS   = (N_CHAN > 2) ? $clog2(N_CHAN) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_CHAN-1:0]             lock_req,
    input  logic [N_CHAN-1:0]             unlock,
    output logic [N_CHAN-1:0]             grant,
    output logic                          locked,
    output logic [CH_BITS-1:0]            owner,
    input  logic [N_CHAN*ADDR_BITS-1:0]   s_addr,
    input  logic [N_CHAN*PID_BITS-1:0]    s_pid,
    input  logic [N_CHAN-1:0]             s_wr,
    input  logic [N_CHAN-1:0]             s_strm,
    input  logic [N_CHAN-1:0]             s_valid,
    output logic [ADDR_BITS-1:0]          m_addr,
    output logic [PID_BITS-1:0]           m_pid,
    output logic                          m_wr,
    output logic                          m_strm,
    output logic                          m_valid,
    output logic                          timeout_irq,
    output logic [CH_BITS-1:0]            timeout_id
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

    typedef enum logic {S_FREE, S_LOCKED} state_t;

    state_t              r_state, w_state_nxt;
    logic [CH_BITS-1:0]  r_owner, w_owner_nxt;
    logic [CH_BITS-1:0]  r_rr_ptr, w_rr_nxt;
    logic [CH_BITS-1:0]  r_timeout_id;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic                r_irq;

    logic                w_own_unlock;
    logic                w_timeout;
    logic                w_release;
    logic                w_arb;
    logic                w_found;
    logic [N_CHAN-1:0]   w_cand;
    logic [CH_BITS-1:0]  w_pick;

    assign w_own_unlock = unlock[r_owner];
    // A same-cycle unlock wins over the timeout, so no interrupt is raised then.
    assign w_timeout    = (MAX_HOLD != 0) && (r_state == S_LOCKED) &&
                          (r_hold_cnt == HOLD_LAST) && !w_own_unlock;
    assign w_release    = (r_state == S_LOCKED) && (w_own_unlock || w_timeout);
    assign w_arb        = (r_state == S_FREE) || w_release;

    always_comb begin
        w_cand  = lock_req;
        w_found = 1'b0;
        w_pick  = '0;
        if (w_release) begin
            w_cand[r_owner] = 1'b0;
        end
        if (PRIO_MODE == 1) begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (!w_found && w_cand[i]) begin
                    w_found = 1'b1;
                    w_pick  = CH_BITS'(i);
                end
            end
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (!w_found && w_cand[(int'(r_rr_ptr) + i) % N_CHAN]) begin
                    w_found = 1'b1;
                    w_pick  = CH_BITS'((int'(r_rr_ptr) + i) % N_CHAN);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        if (w_arb && w_found) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_pick;
            w_rr_nxt    = CH_BITS'((int'(w_pick) + 1) % N_CHAN);
            w_hold_nxt  = '0;
        end else if (w_release) begin
            w_state_nxt = S_FREE;
            w_hold_nxt  = '0;
        end else if ((r_state == S_LOCKED) && (r_hold_cnt != HOLD_MAX)) begin
            w_hold_nxt  = r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= S_FREE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
            r_irq        <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_irq      <= w_timeout;
            if (w_timeout) begin
                r_timeout_id <= r_owner;
            end
        end
    end

    assign locked      = (r_state == S_LOCKED);
    assign owner       = r_owner;
    assign timeout_irq = r_irq;
    assign timeout_id  = r_timeout_id;

    always_comb begin
        grant = '0;
        if (locked) begin
            grant[r_owner] = 1'b1;
        end
    end

    // Lookup mux follows the owner register; valid is gated so FREE issues nothing.
    assign m_addr  = s_addr[int'(r_owner)*ADDR_BITS +: ADDR_BITS];
    assign m_pid   = s_pid[int'(r_owner)*PID_BITS +: PID_BITS];
    assign m_wr    = s_wr[r_owner];
    assign m_strm  = s_strm[r_owner];
    assign m_valid = s_valid[r_owner] & locked;

endmodule
